serial_tx_scheduler: RTL and testbench
======================================

SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters; DATA_W, default 8, bits per frame payload.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 bit_tick  input  1  one-clk strobe marking each bit-period boundary.
REQ-005 req  input  NUM_REQ  per-requester transmit request, level-held until granted.
REQ-006 req_data  input  NUM_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 grant  output  NUM_REQ  one-hot, one-clk pulse; payload of that requester has been captured.
REQ-008 dout  output  1  serial line; idle high.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-clk pulse when a frame's stop bit completes.
REQ-011 All outputs SHALL be registered.

Function
REQ-012 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, stop bit 1.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: dout=1; on an edge with req!=0, the winner's payload is latched into the shift register, grant[winner] is set for one cycle, and the next state is START.
REQ-015 Arbitration SHALL be round-robin: search begins at last_grant+1 modulo NUM_REQ; the first asserted req wins; last_grant updates to the winner.
REQ-016 START: dout=0; on an edge with bit_tick=1, the next state is DATA and bit_cnt=0.
REQ-017 DATA: dout=shift[0]; on an edge with bit_tick=1, the shift register shifts right one bit and bit_cnt increments; when bit_cnt==DATA_W-1 on that edge, the next state is STOP.
REQ-018 STOP: dout=1; on an edge with bit_tick=1, the next state is IDLE and done is set for one cycle.
REQ-019 A bit_tick in the first cycle of a state SHALL count, so each bit lasts at least 1 clk.
REQ-020 bit_tick SHALL be ignored in IDLE.
REQ-021 req changes outside IDLE SHALL NOT affect the current frame.
REQ-022 A requester still asserting req in the cycle after its grant SHALL be treated as a new request.
REQ-023 A req deasserted before the arbitration edge SHALL receive no grant.
REQ-024 Back-to-back frames SHALL spend exactly one cycle in IDLE (dout=1) between the done pulse and the next grant.
REQ-025 grant and done SHALL never be asserted in the same cycle.
REQ-026 bit_cnt width SHALL be clog2(DATA_W); it SHALL NOT wrap within a frame.

Reset
REQ-027 While rst_n=0, outputs SHALL be: state=IDLE, dout=1, busy=0, grant=0, done=0, bit_cnt=0, shift register=0, last_grant=NUM_REQ-1 (requester 0 has first priority).
REQ-028 Reset mid-frame SHALL abort the frame immediately, with no done pulse; the aborted requester is not re-granted automatically.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit), the default NUM_REQ/DATA_W, and the frame bit values (START_BIT=0, STOP_BIT=1).
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: req, last_grant; output: one-hot winner plus winner index), instantiated once.

Verification
REQ-031 Single request: req=4'b0001, req_data[7:0]=8'hA5, bit_tick every 4 clk -> grant=4'b0001 for 1 clk; dout sequence 0,1,0,1,0,0,1,0,1,1; done once.
REQ-032 All requesters held, payloads 8'h11/22/33/44 -> grant order 0,1,2,3,0; exactly one IDLE cycle between each done and the next grant.
REQ-033 bit_tick held high continuously -> frame lasts 10 clk after the grant cycle; dout correct for 8'h3C.
REQ-034 rst_n pulsed low during DATA bit 4 -> dout=1, busy=0 immediately; no done; the next grant goes to requester 0 if requested.
REQ-035 req[2] pulsed for 1 clk during STOP, then dropped -> no grant to requester 2; line stays idle high.
REQ-036 req[1] held through its own frame with req[3] also asserted -> the next grant goes to 3 before 1 is granted again.

Source files
------------

// File: rtl/serial_tx_scheduler_pkg.sv
// Shared constants for the serial transmit scheduler: FSM encoding,
// default geometry and the line levels used for frame delimiters.
package serial_tx_scheduler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_DATA_W  = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: scans upward from last_grant+1 (wrapping)
// and returns the first asserted request as a one-hot vector and an index.
module rr_arbiter
    import serial_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that serialises one requester's payload at a time
// as start bit, LSB-first data, stop bit, paced by an external bit_tick.
module serial_tx_scheduler
    import serial_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bit_tick,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      dout,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [1:0]         state, state_nxt;
    logic [DATA_W-1:0]  shift, shift_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]   last_grant, last_grant_nxt;
    logic [NUM_REQ-1:0] win_onehot, grant_nxt;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_payload;
    logic               dout_nxt, done_nxt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    always_comb begin
        win_payload = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win_onehot[i]) win_payload = win_payload | req_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        bit_cnt_nxt    = bit_cnt;
        last_grant_nxt = last_grant;
        grant_nxt      = '0;
        done_nxt       = 1'b0;
        case (state)
            ST_IDLE: if (|req) begin
                shift_nxt      = win_payload;
                grant_nxt      = win_onehot;
                last_grant_nxt = win_idx;
                bit_cnt_nxt    = '0;
                state_nxt      = ST_START;
            end
            ST_START: if (bit_tick) begin
                bit_cnt_nxt = '0;
                state_nxt   = ST_DATA;
            end
            ST_DATA: if (bit_tick) begin
                shift_nxt = shift >> 1;
                // Hold the counter on the last bit so it never wraps mid-frame.
                if (bit_cnt == CNT_W'(DATA_W - 1)) state_nxt = ST_STOP;
                else bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
            ST_STOP: if (bit_tick) begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The line level is derived from the upcoming state so dout is a flop
    // yet always matches the state it is registered alongside.
    always_comb begin
        case (state_nxt)
            ST_START: dout_nxt = START_BIT;
            ST_DATA:  dout_nxt = shift_nxt[0];
            default:  dout_nxt = STOP_BIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            grant      <= '0;
            dout       <= STOP_BIT;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            last_grant <= last_grant_nxt;
            grant      <= grant_nxt;
            dout       <= dout_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed self-checking bench for serial_tx_scheduler: framing, round-robin
// order, tick pacing, mid-frame reset and request-timing corner cases.
module tb_serial_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      bit_tick;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      dout, busy, done;

    int checks   = 0;
    int failures = 0;

    logic [NUM_REQ-1:0] grant_q[$];
    logic               bits_q[$];
    int                 done_cnt, busy_cycles, seq_err;

    serial_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_tick (bit_tick),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives req_val with a tick every 'period' clocks until n_frames done
    // pulses are seen; records grants, one dout sample per bit, and ordering errors.
    task automatic run_frames(input logic [NUM_REQ-1:0] req_val, input int period,
                              input int n_frames, input int budget);
        int cyc = 0;
        int tick_cnt = 0;
        int last_done = -1;
        grant_q.delete();
        bits_q.delete();
        done_cnt = 0;
        busy_cycles = 0;
        seq_err = 0;
        req = req_val;
        while (done_cnt < n_frames && cyc < budget) begin
            bit_tick = (period <= 1) || (tick_cnt == period - 1);
            tick_cnt = bit_tick ? 0 : tick_cnt + 1;
            if (busy === 1'b1) busy_cycles++;
            if (busy !== 1'b1 && dout !== 1'b1) seq_err++;
            if (grant !== '0) begin
                if (done !== 1'b0) seq_err++;
                if (last_done >= 0 && cyc - last_done != 1) seq_err++;
                last_done = -1;
                grant_q.push_back(grant);
                if (grant_q.size() >= n_frames) req = '0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done = cyc;
            end
            if (busy === 1'b1 && bit_tick) bits_q.push_back(dout);
            step();
            cyc++;
        end
        bit_tick = 1'b0;
        req = '0;
        checks++;
        if (done_cnt != n_frames) begin
            failures++;
            $display("FAIL frame_timeout: done pulses=%0d required=%0d", done_cnt, n_frames);
        end
    endtask

    function automatic logic [9:0] get_frame(input int idx);
        logic [9:0] f;
        for (int j = 0; j < 10; j++)
            f[j] = (idx*10 + j < bits_q.size()) ? bits_q[idx*10 + j] : 1'bx;
        return f;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bit_tick = 1'b0;
        req = '0;
        req_data = '0;
        repeat (3) step();
        checks++;
        if (dout !== 1'b1) begin failures++; $display("FAIL reset_dout: got %b want 1", dout); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0]         exp_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        run_frames(4'b1111, 3, 5, 400);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= grant_q.size() || grant_q[k] !== exp_g[k]) begin
                failures++;
                $display("FAIL rr_grant_%0d: got %b want %b", k,
                         (k < grant_q.size()) ? grant_q[k] : 4'bxxxx, exp_g[k]);
            end
            checks++;
            if (get_frame(k) !== {1'b1, exp_b[k], 1'b0}) begin
                failures++;
                $display("FAIL rr_frame_%0d: got %b want %b", k, get_frame(k), {1'b1, exp_b[k], 1'b0});
            end
        end
        checks++;
        if (seq_err != 0) begin failures++; $display("FAIL rr_idle_gap: errors=%0d want 0", seq_err); end
    endtask

    task automatic test_single();
        req_data = '0;
        req_data[7:0] = 8'hA5;
        run_frames(4'b0001, 4, 1, 200);
        checks++;
        if (grant_q.size() != 1 || grant_q[0] !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: count=%0d first=%b want 1 x 0001", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0] : 4'bxxxx);
        end
        checks++;
        if (get_frame(0) !== 10'b11_0100_1010 || bits_q.size() != 10) begin
            failures++;
            $display("FAIL single_frame: got %b (%0d bits) want 1101001010", get_frame(0), bits_q.size());
        end
        checks++;
        if (done_cnt != 1 || seq_err != 0) begin
            failures++;
            $display("FAIL single_done: done=%0d seq_err=%0d want 1/0", done_cnt, seq_err);
        end
    endtask

    task automatic test_fast_tick();
        req_data = '0;
        req_data[23:16] = 8'h3C;
        run_frames(4'b0100, 1, 1, 100);
        checks++;
        if (grant_q.size() != 1 || grant_q[0] !== 4'b0100) begin
            failures++;
            $display("FAIL fast_grant: count=%0d want one 0100", grant_q.size());
        end
        checks++;
        if (get_frame(0) !== 10'b10_0111_1000) begin
            failures++;
            $display("FAIL fast_frame: got %b want 1001111000", get_frame(0));
        end
        checks++;
        if (busy_cycles != 10) begin
            failures++;
            $display("FAIL fast_length: busy cycles=%0d want 10", busy_cycles);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int bad = 0;
        req_data = '0;
        req_data[23:16] = 8'h5A;
        req = 4'b0100;
        bit_tick = 1'b1;
        while (grant === 4'b0000 && n < 20) begin step(); n++; end
        req = '0;
        checks++;
        if (grant !== 4'b0100) begin failures++; $display("FAIL abort_grant: got %b want 0100", grant); end
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b1) begin failures++; $display("FAIL abort_dout: got %b want 1", dout); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        step();
        rst_n = 1'b1;
        bit_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b1 || grant !== '0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL abort_quiet: bad cycles=%0d want 0", bad); end
        req_data = {8'h04, 8'h03, 8'h02, 8'h01};
        run_frames(4'b1111, 2, 1, 200);
        checks++;
        if (grant_q.size() < 1 || grant_q[0] !== 4'b0001) begin
            failures++;
            $display("FAIL abort_next_grant: got %b want 0001", (grant_q.size() > 0) ? grant_q[0] : 4'bxxxx);
        end
    endtask

    task automatic test_req_pulse_stop();
        int n = 0;
        int bad = 0;
        req_data = '0;
        req_data[7:0] = 8'hC3;
        req_data[23:16] = 8'hEE;
        req = 4'b0001;
        bit_tick = 1'b1;
        while (grant === 4'b0000 && n < 20) begin step(); n++; end
        req = '0;
        repeat (9) step();
        checks++;
        if (busy !== 1'b1 || dout !== 1'b1) begin
            failures++;
            $display("FAIL pulse_stop_state: busy=%b dout=%b want 1/1", busy, dout);
        end
        req = 4'b0100;
        step();
        req = '0;
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL pulse_done: got %b want 1", done); end
        for (int i = 0; i < 20; i++) begin
            if (grant !== '0 || dout !== 1'b1 || busy !== 1'b0) bad++;
            step();
        end
        bit_tick = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL pulse_no_grant: bad cycles=%0d want 0", bad); end
    endtask

    task automatic test_back_to_back_held();
        logic [NUM_REQ-1:0] exp_g[3] = '{4'b0010, 4'b1000, 4'b0010};
        req_data = {8'h88, 8'h00, 8'h77, 8'h00};
        run_frames(4'b1010, 2, 3, 400);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k >= grant_q.size() || grant_q[k] !== exp_g[k]) begin
                failures++;
                $display("FAIL held_grant_%0d: got %b want %b", k,
                         (k < grant_q.size()) ? grant_q[k] : 4'bxxxx, exp_g[k]);
            end
        end
        checks++;
        if (get_frame(1) !== {1'b1, 8'h88, 1'b0}) begin
            failures++;
            $display("FAIL held_frame_3: got %b want %b", get_frame(1), {1'b1, 8'h88, 1'b0});
        end
        checks++;
        if (seq_err != 0) begin failures++; $display("FAIL held_idle_gap: errors=%0d want 0", seq_err); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fast_tick();
        test_reset_mid_frame();
        test_req_pulse_stop();
        test_back_to_back_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
